// File: rtl/ifetch_ctrl_pkg.sv
// Shared constants and fetch-state encoding for the instruction-fetch controller.
package ifetch_ctrl_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ifetch_hold_buf.sv
// One-entry pc/instruction holding register used when decode is backpressuring.
module ifetch_hold_buf
  import ifetch_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_inst,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [31:0]     o_inst
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_inst;

  // Flush wins over load: a redirect must never let stale contents survive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_inst  <= i_inst;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: one outstanding imem read, registered IF output, redirect flush.
// Optional performance counters enabled by defining IFETCH_PERF_EN.
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] current_pc,
  output logic [XLEN-1:0] next_pc,
  output logic            pc_stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_inst
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_drop_cnt
`endif
);

  fetch_state_t    r_state;
  logic            r_drop;
  logic            r_addr_cap;
  logic [XLEN-1:0] r_addr;
  logic            r_if_valid;
  logic [XLEN-1:0] r_if_pc;
  logic [31:0]     r_if_inst;

  logic            w_free;
  logic            w_rsp;
  logic            w_rsp_keep;
  logic            w_deliver_new;
  logic            w_to_hold;
  logic            w_deliver_hold;
  logic            w_discard;
  logic            w_hold_flush;
  logic            w_hold_valid;
  logic [XLEN-1:0] w_hold_pc;
  logic [31:0]     w_hold_inst;

  assign w_free         = !r_if_valid || !id_stall;
  assign w_rsp          = (r_state == WAIT) && imem_rvalid;
  assign w_rsp_keep     = w_rsp && !r_drop && !redirect_valid;
  assign w_deliver_new  = w_rsp_keep && w_free;
  assign w_to_hold      = w_rsp_keep && !w_free;
  assign w_deliver_hold = (r_state == HOLD) && w_free && !redirect_valid;
  assign w_discard      = (w_rsp && (r_drop || redirect_valid)) ||
                          ((r_state == HOLD) && redirect_valid);
  assign w_hold_flush   = redirect_valid || w_deliver_hold;

  assign next_pc  = redirect_valid ? redirect_pc : current_pc + XLEN'(INST_BYTES);
  assign pc_stall = !(redirect_valid || w_deliver_new || w_deliver_hold);

  // The first REQ cycle forwards current_pc directly so zero-wait memory sees it at once.
  assign imem_req  = (r_state == REQ);
  assign imem_addr = ((r_state == REQ) && !r_addr_cap) ? current_pc : r_addr;

  ifetch_hold_buf u_hold (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_to_hold),
    .i_flush (w_hold_flush),
    .i_pc    (r_addr),
    .i_inst  (imem_rdata),
    .o_valid (w_hold_valid),
    .o_pc    (w_hold_pc),
    .o_inst  (w_hold_inst)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= REQ;
      r_drop     <= 1'b0;
      r_addr_cap <= 1'b0;
      r_addr     <= '0;
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_inst  <= '0;
    end else begin
      case (r_state)
        REQ: begin
          if (!r_addr_cap) r_addr <= current_pc;
          if (imem_ready) begin
            r_state    <= WAIT;
            r_addr_cap <= 1'b0;
          end else begin
            r_addr_cap <= 1'b1;
          end
          if (redirect_valid) r_drop <= 1'b1;
        end
        WAIT: begin
          if (imem_rvalid) begin
            r_drop  <= 1'b0;
            r_state <= (w_rsp_keep && !w_free) ? HOLD : REQ;
          end else if (redirect_valid) begin
            r_drop <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid || w_free) r_state <= REQ;
        end
        default: r_state <= REQ;
      endcase

      // Decode-facing register: redirect clears, delivery loads, otherwise drain when accepted.
      if (redirect_valid) begin
        r_if_valid <= 1'b0;
      end else if (w_deliver_new) begin
        r_if_valid <= 1'b1;
        r_if_pc    <= r_addr;
        r_if_inst  <= imem_rdata;
      end else if (w_deliver_hold && w_hold_valid) begin
        r_if_valid <= 1'b1;
        r_if_pc    <= w_hold_pc;
        r_if_inst  <= w_hold_inst;
      end else if (!id_stall) begin
        r_if_valid <= 1'b0;
      end
    end
  end

  assign if_valid = r_if_valid;
  assign if_pc    = r_if_pc;
  assign if_inst  = r_if_inst;

`ifdef IFETCH_PERF_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_drop_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_stall_cnt <= '0;
      r_perf_drop_cnt  <= '0;
    end else begin
      if (pc_stall)  r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      if (w_discard) r_perf_drop_cnt  <= r_perf_drop_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall_cnt;
  assign perf_drop_cnt  = r_perf_drop_cnt;
`else
  logic w_unused;
  assign w_unused = w_discard;
`endif

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Instruction-fetch controller; produces `next_pc`/`pc_stall` for the PC register and consumes its `current_pc`.
- Issues one-outstanding read requests to instruction memory over a req/ready + rvalid handshake.
- Delivers a registered instruction/PC pair to decode, with backpressure and branch redirect/flush.

Parameters:
- XLEN, 32, address/data width.
- INST_BYTES, 4, sequential PC increment.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- current_pc  in  XLEN  PC register output
- next_pc  out  XLEN  PC register input
- pc_stall  out  1  PC register hold
- redirect_valid  in  1  branch/jump taken, one-cycle pulse
- redirect_pc  in  XLEN  redirect target
- id_stall  in  1  decode cannot accept
- imem_req  out  1  read request
- imem_addr  out  XLEN  request address, latched
- imem_ready  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid, exactly one per accepted request
- imem_rdata  in  32  instruction word
- if_valid  out  1  instruction to decode valid
- if_pc  out  XLEN  PC of if_inst
- if_inst  out  32  instruction

Behaviour:
- Reset values:
  - state=REQ, drop=0, hold_valid=0.
  - if_valid=0, if_pc=0, if_inst=0.
  - imem_addr is loaded from current_pc on the first cycle after reset.
  - imem_req=1 from the first cycle after reset deassertion.
- next_pc (combinational): redirect_valid ? redirect_pc : current_pc+INST_BYTES, modulo 2^XLEN so 0xFFFFFFFC wraps to 0.
- pc_stall (combinational): 0 only in the following cases, otherwise 1.
  - (a) redirect_valid.
  - (b) A non-dropped response is moved into the output register this cycle.
- Output register "free" = !if_valid || !id_stall.
- REQ state:
  - imem_req=1, imem_addr=addr_q. addr_q is captured from current_pc on entry and held stable until imem_ready.
  - imem_ready -> WAIT.
- WAIT state:
  - imem_req=0; on imem_rvalid, one of three outcomes:
  - drop=1: discard, clear drop -> REQ.
  - Output free: load if_pc=addr_q, if_inst=rdata, if_valid=1; pc advances -> REQ.
  - Otherwise: store in hold reg -> HOLD.
- HOLD state:
  - imem_req=0.
  - When output is free: hold -> output register, pc advances -> REQ.
- Redirect handling (any cycle, highest priority):
  - if_valid cleared next cycle; hold contents discarded.
  - In REQ with imem_req pending, or in WAIT without same-cycle rvalid: drop=1. The in-flight response is discarded later; the next REQ uses the redirected current_pc.
  - WAIT with same-cycle rvalid: response discarded, -> REQ.
  - HOLD: -> REQ.
  - A redirect arriving while drop=1 leaves drop=1; only one response is outstanding.
- Without a delivery, if_valid is cleared when !id_stall. It is held with if_pc/if_inst stable while id_stall.
- Zero-wait memory (ready same cycle, rvalid next cycle) gives one instruction per 2 cycles; latency current_pc -> if_valid is 2 cycles.
- Reset mid-transaction: all state returns to reset values asynchronously. Any late rvalid before the first accepted request is ignored.

Optional Feature:
- IFETCH_PERF_EN defined: adds outputs perf_stall_cnt[31:0] and perf_drop_cnt[31:0].
  - perf_stall_cnt counts cycles with pc_stall=1.
  - perf_drop_cnt counts discarded responses.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package: XLEN, INST_BYTES, fetch state encoding (REQ=2'd0, WAIT=2'd1, HOLD=2'd2), NOP instruction constant 32'h00000013 for bench use.
- One natural sub-module: ifetch_hold_buf, a one-entry pc/inst holding register with valid, load, and flush.

Test Plan:
- Reset, zero-wait memory returning rdata=addr^0xA5A5A5A5 -> if_pc sequence 0,4,8,C on every second cycle; first if_valid 2 cycles after reset deassert.
- id_stall high 3 cycles while if_pc=8 -> if_pc/if_inst stable. Next response held in HOLD with pc_stall=1; delivers 0xC on the cycle after id_stall drops.
- Redirect to 0x100 while in WAIT (rvalid 2 cycles later) -> stale response discarded; next imem_addr=0x100; if_valid=0 until if_pc=0x100.
- Redirect coincident with rvalid in WAIT -> response discarded; next request addr=target; no instruction from the old path reaches decode.
- imem_ready low 4 cycles -> imem_req held, imem_addr stable at 0x10; current_pc stable.
- current_pc=0xFFFFFFFC -> next_pc=0; with IFETCH_PERF_EN, perf_drop_cnt=1 after one redirect-in-flight.
